tile_line_sequencer: RTL and testbench
======================================

Name: tile_line_sequencer

Overview:
- Per-scanline controller that fetches tilemap entries and 4bpp pattern words from VRAM and feeds them to the 4-pixel-per-word line renderer.
- Sits between the video timing generator (line_start pulse), the VRAM arbiter (request/acknowledge read port) and the renderer (render_start/render_idx/render_data).
- Applies X/Y scroll and per-tile H/V flip.

Parameters:
- NUM_TILES, 41, tiles rendered per line (40 visible plus 1 for fine X scroll).
- TILEMAP_BASE, 13'h1800, word address of the 64x32 tilemap.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- line_start  in  1  one-cycle pulse; begin rendering the line given by vline
- vline  in  8  line number to render (sampled on line_start)
- scrollx  in  9  horizontal scroll in pixels (sampled on line_start)
- scrolly  in  8  vertical scroll in pixels (sampled on line_start)
- enable  in  1  when 0, line_start is ignored
- vaddr  out  13  VRAM word address
- vren  out  1  read request; held with vaddr stable until vack
- vack  in  1  request accepted; vrdata valid in the same cycle
- vrdata  in  16  VRAM read data
- render_start  out  1  one-cycle pulse to renderer
- render_idx  out  9  line buffer start index
- render_data  out  16  pattern word
- render_busy  in  1  renderer busy
- render_last_pixel  in  1  renderer writing its final pixel
- active  out  1  line in progress
- line_done  out  1  one-cycle pulse after last word issued

Behaviour:
- Reset: state IDLE; vren=0, vaddr=0, render_start=0, render_idx=0, render_data=0, active=0, line_done=0.
- States: IDLE -> MAP -> PAT0 -> PAT1 -> ISS0 -> ISS1 -> MAP (next tile) or DONE -> IDLE.
- IDLE: on line_start && enable, latch the inputs and compute y = vline+scrolly (mod 256). Set tile counter n=0, col = scrollx[8:3], active=1. Go to MAP.
- MAP: vaddr = TILEMAP_BASE + {y[7:3], col[5:0]}, vren=1. On vack, latch the entry: tile=vrdata[8:0], hflip=vrdata[9], vflip=vrdata[10]; bits 15:11 are ignored.
- Fine row: fy = vflip ? ~y[2:0] : y[2:0].
- PAT0/PAT1: vaddr = {tile, fy, h} with h = 0 then 1 (wraps within 13 bits; aliasing with the tilemap is allowed). Each fetch waits for vack and latches the word into w0/w1.
- Renderer pixel order per word is vrdata bits 7:4, 3:0, 15:12, 11:8.
- hflip=0: issue w0 then w1, unmodified.
- hflip=1: issue w1 then w0, each transformed to {w[3:0], w[7:4], w[11:8], w[15:12]} so pixel order is reversed.
- ISS0/ISS1: assert render_start only in a cycle where render_busy==0 or render_last_pixel==1, so words can go back-to-back. render_idx = n*8 - scrollx[2:0] (+4 in ISS1), mod 512. Negative indices wrap to 505..511 and land off-screen, which is intended.
- After ISS1: n++, col++ (mod 64). If n==NUM_TILES go to DONE, else MAP.
- DONE: line_done=1 for one cycle, active=0, then IDLE.
- vren is deasserted in the cycle after vack unless the next state issues a new request. Back-to-back requests are allowed.
- vaddr is held unchanged while vren=1 and vack=0.
- line_start while active: abort the current line and restart with new inputs.
  - An outstanding request is dropped without waiting for vack.
  - No line_done for the aborted line.
  - A render_start already issued is not recalled.
- line_start coinciding with the DONE cycle: line_done still pulses and the new line starts next cycle.
- vack while vren=0 is ignored.
- render_start is never asserted when render_busy=1 and render_last_pixel=0.

Test Plan:
- Scroll 0: vline=0, scrolly=0, scrollx=0, entry 0x0005 at 0x1800, pattern 0x5000=0x2143, 0x5001=0x6587 -> vaddr sequence 0x1800, 0x0050, 0x0051. render_start with idx 0 data 0x2143, then idx 4 data 0x6587. 41 tiles, then line_done.
- hflip: entry 0x0205, same pattern -> first issue idx 0 data 0x7856 (from 0x6587), then idx 4 data 0x3412.
- vflip + scroll: vline=3, scrolly=9, scrollx=13 -> y=12. Map addr 0x1800+64+1=0x1841. vflip entry 0x0405 gives fy=3, pattern addrs 0x0056/0x0057. First render_idx=507, second=511, third=3.
- Arbiter stall: vack delayed 5 cycles on each fetch -> vaddr/vren stable throughout and no extra requests. Zero-wait vack -> consecutive render_starts exactly 4 cycles apart.
- Abort: line_start at tile 10 -> restart from n=0 with new vline, exactly one line_done. enable=0 -> line_start ignored.
- Reset mid-line (during PAT1 with vren=1) -> next cycle vren=0, active=0, no render_start until the next line_start.

Source files
------------

// File: rtl/tile_line_sequencer.sv
// Per-scanline tile fetch sequencer: reads tilemap entries and 4bpp pattern words
// from VRAM, applies scroll and flips, and hands words to the line renderer.
module tile_line_sequencer #(
   parameter int          NUM_TILES    = 41,
   parameter logic [12:0] TILEMAP_BASE = 13'h1800
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        line_start,
   input  logic [7:0]  vline,
   input  logic [8:0]  scrollx,
   input  logic [7:0]  scrolly,
   input  logic        enable,
   output logic [12:0] vaddr,
   output logic        vren,
   input  logic        vack,
   input  logic [15:0] vrdata,
   output logic        render_start,
   output logic [8:0]  render_idx,
   output logic [15:0] render_data,
   input  logic        render_busy,
   input  logic        render_last_pixel,
   output logic        active,
   output logic        line_done
);

   localparam int            NW     = $clog2(NUM_TILES + 1);
   localparam logic [NW-1:0] LAST_N = NW'(NUM_TILES - 1);

   typedef enum logic [2:0] {
      IDLE,
      MAP,
      PAT0,
      PAT1,
      ISS0,
      ISS1,
      DONE
   } state_t;

   state_t        state;
   logic [7:0]    y;
   logic [2:0]    fx;
   logic [5:0]    col;
   logic [NW-1:0] n;
   logic [8:0]    tile;
   logic [2:0]    fy;
   logic          hflip;
   logic [15:0]   w0;
   logic [15:0]   w1;

   logic [7:0]    y_start;
   logic [2:0]    fy_entry;
   logic [5:0]    col_next;
   logic          start_line;
   logic          issue;

   // Reverses the renderer pixel order (7:4, 3:0, 15:12, 11:8) within one word.
   function automatic logic [15:0] mirror(input logic [15:0] w);
      return {w[3:0], w[7:4], w[11:8], w[15:12]};
   endfunction

   function automatic logic [12:0] map_addr(input logic [7:0] yy, input logic [5:0] cc);
      return TILEMAP_BASE + {2'b00, yy[7:3], cc};
   endfunction

   assign y_start    = vline + scrolly;
   assign start_line = line_start && enable;
   assign fy_entry   = vrdata[10] ? ~y[2:0] : y[2:0];
   assign col_next   = col + 6'd1;

   // Issue may coincide with the renderer's final pixel so words stream back-to-back.
   assign issue        = ((state == ISS0) || (state == ISS1)) && (!render_busy || render_last_pixel);
   assign render_start = issue;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         vren        <= 1'b0;
         vaddr       <= 13'd0;
         render_idx  <= 9'd0;
         render_data <= 16'd0;
         active      <= 1'b0;
         line_done   <= 1'b0;
      end else begin
         line_done <= 1'b0;
         if (start_line) begin
            // A new line pre-empts everything, including an unacknowledged request.
            y      <= y_start;
            fx     <= scrollx[2:0];
            col    <= scrollx[8:3];
            n      <= '0;
            active <= 1'b1;
            vren   <= 1'b1;
            vaddr  <= map_addr(y_start, scrollx[8:3]);
            state  <= MAP;
         end else begin
            case (state)
               IDLE: begin
                  vren <= 1'b0;
               end
               MAP: begin
                  if (vack) begin
                     tile  <= vrdata[8:0];
                     hflip <= vrdata[9];
                     fy    <= fy_entry;
                     vaddr <= {vrdata[8:0], fy_entry, 1'b0};
                     state <= PAT0;
                  end
               end
               PAT0: begin
                  if (vack) begin
                     w0    <= vrdata;
                     vaddr <= {tile, fy, 1'b1};
                     state <= PAT1;
                  end
               end
               PAT1: begin
                  if (vack) begin
                     w1          <= vrdata;
                     vren        <= 1'b0;
                     render_data <= hflip ? mirror(vrdata) : w0;
                     render_idx  <= 9'({n, 3'b000}) - {6'd0, fx};
                     state       <= ISS0;
                  end
               end
               ISS0: begin
                  if (issue) begin
                     render_data <= hflip ? mirror(w0) : w1;
                     render_idx  <= render_idx + 9'd4;
                     state       <= ISS1;
                  end
               end
               ISS1: begin
                  if (issue) begin
                     n   <= n + 1'b1;
                     col <= col_next;
                     if (n == LAST_N) begin
                        line_done <= 1'b1;
                        active    <= 1'b0;
                        state     <= DONE;
                     end else begin
                        vren  <= 1'b1;
                        vaddr <= map_addr(y, col_next);
                        state <= MAP;
                     end
                  end
               end
               DONE: begin
                  state <= IDLE;
               end
               default: begin
                  vren  <= 1'b0;
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_tile_line_sequencer.sv
// Randomized bench for tile_line_sequencer with a pixel-level reference model,
// a random-latency VRAM arbiter and a 4-cycle-per-word renderer model.
module tb_tile_line_sequencer;

   localparam int NT = 41;

   logic        clk = 1'b0;
   logic        reset;
   logic        line_start;
   logic [7:0]  vline;
   logic [8:0]  scrollx;
   logic [7:0]  scrolly;
   logic        enable;
   logic [12:0] vaddr;
   logic        vren;
   logic        vack = 1'b0;
   logic [15:0] vrdata = 16'd0;
   logic        render_start;
   logic [8:0]  render_idx;
   logic [15:0] render_data;
   logic        render_busy;
   logic        render_last_pixel;
   logic        active;
   logic        line_done;

   tile_line_sequencer dut (
      .clk(clk), .reset(reset), .line_start(line_start), .vline(vline),
      .scrollx(scrollx), .scrolly(scrolly), .enable(enable), .vaddr(vaddr),
      .vren(vren), .vack(vack), .vrdata(vrdata), .render_start(render_start),
      .render_idx(render_idx), .render_data(render_data), .render_busy(render_busy),
      .render_last_pixel(render_last_pixel), .active(active), .line_done(line_done)
   );

   always #5 clk = ~clk;

   logic [15:0] mem [8192];
   int          n_checks = 0;
   int          n_pass = 0;
   int          stall_mode = 0;
   int          stall = 0;
   int          cyc = 0;
   int          done_cnt = 0;
   int          rcnt = 0;
   logic        hold_pending = 1'b0;
   logic [12:0] hold_addr = 13'd0;

   logic [12:0] acc_q[$];
   logic [24:0] ev_q[$];
   int          st_q[$];
   logic [12:0] exp_acc[$];
   logic [24:0] exp_ev[$];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // Renderer: busy for 4 cycles after each word, last pixel on the 4th.
   always @(posedge clk) begin
      if (render_start) rcnt <= 4;
      else if (rcnt > 0) rcnt <= rcnt - 1;
   end
   assign render_busy       = (rcnt != 0);
   assign render_last_pixel = (rcnt == 1);

   function automatic int next_delay();
      case (stall_mode)
         1:       return 0;
         2:       return 5;
         default: return int'($urandom_range(0, 3));
      endcase
   endfunction

   // VRAM arbiter and output monitor share one process so their ordering is fixed.
   initial begin : arb_mon
      forever begin
         @(negedge clk);
         cyc++;
         if (vren) begin
            if (stall <= 0) begin
               vack   = 1'b1;
               vrdata = mem[vaddr];
               stall  = next_delay();
            end else begin
               vack   = 1'b0;
               vrdata = 16'($urandom);
               stall--;
            end
         end else begin
            vack   = (stall_mode == 0) && ($urandom_range(0, 3) == 0);
            vrdata = 16'($urandom);
         end
         if (!reset) begin
            if (hold_pending) check_val("vaddr_hold", {18'd0, vren, vaddr}, {18'd0, 1'b1, hold_addr});
            hold_pending = vren && !vack && !line_start;
            hold_addr    = vaddr;
            if (vren && vack) acc_q.push_back(vaddr);
            if (render_start) begin
               ev_q.push_back({render_idx, render_data});
               st_q.push_back(cyc);
               check_val("start_gate", {31'd0, render_busy && !render_last_pixel}, 32'd0);
            end
            if (line_done) done_cnt++;
         end else begin
            hold_pending = 1'b0;
         end
      end
   end

   task automatic build_model(input logic [7:0] vl, input logic [8:0] sx, input logic [7:0] sy);
      int y, fx, col, ma, tile, fy, pa, idx;
      logic [15:0] ent, p0, p1;
      logic [3:0] px[8];
      logic [3:0] rp[8];
      exp_acc.delete();
      exp_ev.delete();
      y  = (int'(vl) + int'(sy)) % 256;
      fx = int'(sx) % 8;
      for (int n = 0; n < NT; n++) begin
         col  = (int'(sx) / 8 + n) % 64;
         ma   = 'h1800 + (y / 8) * 64 + col;
         ent  = mem[ma];
         tile = int'(ent) % 512;
         fy   = ent[10] ? 7 - (y % 8) : y % 8;
         pa   = (tile * 16 + fy * 2) % 8192;
         exp_acc.push_back(13'(ma));
         exp_acc.push_back(13'(pa));
         exp_acc.push_back(13'(pa + 1));
         p0 = mem[pa];
         p1 = mem[pa + 1];
         px[0] = p0[7:4]; px[1] = p0[3:0]; px[2] = p0[15:12]; px[3] = p0[11:8];
         px[4] = p1[7:4]; px[5] = p1[3:0]; px[6] = p1[15:12]; px[7] = p1[11:8];
         for (int k = 0; k < 8; k++) rp[k] = ent[9] ? px[7 - k] : px[k];
         idx = (n * 8 - fx + 512) % 512;
         exp_ev.push_back({9'(idx), rp[2], rp[3], rp[0], rp[1]});
         exp_ev.push_back({9'((idx + 4) % 512), rp[6], rp[7], rp[4], rp[5]});
      end
   endtask

   task automatic clear_obs();
      acc_q.delete();
      ev_q.delete();
      st_q.delete();
      done_cnt = 0;
   endtask

   task automatic start_line(input logic [7:0] vl, input logic [8:0] sx, input logic [7:0] sy);
      @(posedge clk); #1;
      vline = vl; scrollx = sx; scrolly = sy; line_start = 1'b1;
      @(posedge clk); #1;
      line_start = 1'b0;
      vline = 8'($urandom); scrollx = 9'($urandom); scrolly = 8'($urandom);
      clear_obs();
      check_val("active_on", {31'd0, active}, {31'd0, enable});
   endtask

   task automatic wait_done(input string tag);
      for (int i = 0; i < 6000 && done_cnt == 0; i++) @(posedge clk);
      repeat (12) @(posedge clk);
      #1;
      check_val({tag, "_done_cnt"}, done_cnt, 1);
      check_val({tag, "_active_off"}, {31'd0, active}, 32'd0);
   endtask

   task automatic compare(input string tag);
      check_val({tag, "_req_count"}, acc_q.size(), exp_acc.size());
      for (int i = 0; i < exp_acc.size() && i < acc_q.size(); i++)
         check_val($sformatf("%s_req%0d", tag, i), {19'd0, acc_q[i]}, {19'd0, exp_acc[i]});
      check_val({tag, "_issue_count"}, ev_q.size(), exp_ev.size());
      for (int i = 0; i < exp_ev.size() && i < ev_q.size(); i++)
         check_val($sformatf("%s_issue%0d", tag, i), {7'd0, ev_q[i]}, {7'd0, exp_ev[i]});
   endtask

   task automatic run_line(input string tag, input logic [7:0] vl, input logic [8:0] sx,
                           input logic [7:0] sy);
      build_model(vl, sx, sy);
      start_line(vl, sx, sy);
      wait_done(tag);
      compare(tag);
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not finish within the time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int bad;
      logic found;
      logic [7:0] bv, bsy;
      logic [8:0] bsx;
      reset = 1'b1; line_start = 1'b0; enable = 1'b1;
      vline = 8'd0; scrollx = 9'd0; scrolly = 8'd0;
      for (int i = 0; i < 8192; i++) mem[i] = 16'($urandom);

      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      check_val("rst_vren", {31'd0, vren}, 32'd0);
      check_val("rst_vaddr", {19'd0, vaddr}, 32'd0);
      check_val("rst_active", {31'd0, active}, 32'd0);
      check_val("rst_line_done", {31'd0, line_done}, 32'd0);
      check_val("rst_render_start", {31'd0, render_start}, 32'd0);
      check_val("rst_render_idx", {23'd0, render_idx}, 32'd0);
      check_val("rst_render_data", {16'd0, render_data}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      mem['h1800] = 16'h0005; mem['h0050] = 16'h2143; mem['h0051] = 16'h6587;
      run_line("scroll0", 8'd0, 9'd0, 8'd0);
      check_val("s0_map_addr", {19'd0, acc_q[0]}, 32'h1800);
      check_val("s0_pat0_addr", {19'd0, acc_q[1]}, 32'h0050);
      check_val("s0_pat1_addr", {19'd0, acc_q[2]}, 32'h0051);
      check_val("s0_first_issue", {7'd0, ev_q[0]}, {7'd0, 9'd0, 16'h2143});
      check_val("s0_second_issue", {7'd0, ev_q[1]}, {7'd0, 9'd4, 16'h6587});

      mem['h1800] = 16'h0205;
      run_line("hflip", 8'd0, 9'd0, 8'd0);
      check_val("hf_first_issue", {7'd0, ev_q[0]}, {7'd0, 9'd0, 16'h7856});
      check_val("hf_second_issue", {7'd0, ev_q[1]}, {7'd0, 9'd4, 16'h3412});

      mem['h1841] = 16'h0405;
      run_line("vflip", 8'd3, 9'd13, 8'd9);
      check_val("vf_map_addr", {19'd0, acc_q[0]}, 32'h1841);
      check_val("vf_pat0_addr", {19'd0, acc_q[1]}, 32'h0056);
      check_val("vf_pat1_addr", {19'd0, acc_q[2]}, 32'h0057);
      check_val("vf_idx0", {23'd0, ev_q[0][24:16]}, 32'd507);
      check_val("vf_idx1", {23'd0, ev_q[1][24:16]}, 32'd511);
      check_val("vf_idx2", {23'd0, ev_q[2][24:16]}, 32'd3);

      stall_mode = 2; stall = 5;
      run_line("stall5", 8'($urandom), 9'($urandom), 8'($urandom));
      check_val("stall5_requests", acc_q.size(), 3 * NT);

      stall_mode = 1; stall = 0;
      run_line("zerowait", 8'($urandom), 9'($urandom), 8'($urandom));
      bad = 0;
      for (int i = 1; i < st_q.size(); i++) if (st_q[i] - st_q[i - 1] != 4) bad++;
      check_val("zw_spacing_bad", bad, 0);
      check_val("zw_start_count", st_q.size(), 2 * NT);

      stall_mode = 0;
      for (int t = 0; t < 4; t++)
         run_line($sformatf("rand%0d", t), 8'($urandom), 9'($urandom), 8'($urandom));

      // Abort around tile 10 and restart with different parameters.
      start_line(8'($urandom), 9'($urandom), 8'($urandom));
      for (int i = 0; i < 6000 && ev_q.size() < 20; i++) @(posedge clk);
      check_val("abort_reached_tile10", {31'd0, ev_q.size() >= 20}, 32'd1);
      repeat ($urandom_range(0, 6)) @(posedge clk);
      run_line("abort_new", 8'($urandom), 9'($urandom), 8'($urandom));

      enable = 1'b0;
      start_line(8'($urandom), 9'($urandom), 8'($urandom));
      repeat (30) @(posedge clk);
      #1;
      check_val("dis_requests", acc_q.size(), 0);
      check_val("dis_issues", ev_q.size(), 0);
      check_val("dis_vren", {31'd0, vren}, 32'd0);
      enable = 1'b1;

      // New line requested in the very cycle line_done is high.
      build_model(8'd77, 9'd301, 8'd200);
      start_line(8'd77, 9'd301, 8'd200);
      found = 1'b0;
      for (int i = 0; i < 6000 && !found; i++) begin
         @(negedge clk); #1;
         if (line_done) found = 1'b1;
      end
      check_val("coin_done_seen", {31'd0, found}, 32'd1);
      check_val("coin_first_done_cnt", done_cnt, 1);
      compare("coin_first");
      bv = 8'($urandom); bsx = 9'($urandom); bsy = 8'($urandom);
      vline = bv; scrollx = bsx; scrolly = bsy; line_start = 1'b1;
      @(posedge clk); #1;
      line_start = 1'b0;
      clear_obs();
      check_val("coin_active_next", {31'd0, active}, 32'd1);
      build_model(bv, bsx, bsy);
      wait_done("coin_second");
      compare("coin_second");

      // Synchronous reset while a second pattern fetch is outstanding.
      start_line(8'($urandom), 9'($urandom), 8'($urandom));
      found = 1'b0;
      for (int i = 0; i < 6000 && !found; i++) begin
         @(posedge clk); #1;
         if (vren && (acc_q.size() % 3 == 2)) found = 1'b1;
      end
      check_val("rst_mid_reached", {31'd0, found}, 32'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check_val("rst_mid_vren", {31'd0, vren}, 32'd0);
      check_val("rst_mid_active", {31'd0, active}, 32'd0);
      clear_obs();
      repeat (30) @(posedge clk);
      #1;
      check_val("rst_mid_no_issue", ev_q.size(), 0);
      check_val("rst_mid_no_request", acc_q.size(), 0);

      run_line("after_reset", 8'($urandom), 9'($urandom), 8'($urandom));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
